// File: rtl/data_split_pkg.sv
// Shared definitions for the 48-bit word to UART byte splitter.
package data_split_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam int FRAME_BYTES = 6;
  localparam int WD_W        = 27;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

endpackage

// File: rtl/data_split.sv
// Splits a 48-bit word into six bytes for a UART transmitter, MSB first,
// with a one-word holding buffer so a second word can queue behind the first.
module data_split
  import data_split_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int WD_CYCLES  = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] data_i,
  input  logic        data_en,
  output logic        ready_o,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy_o,
  output logic [2:0]  o_byte_cnt,
  output logic        done,
  output logic        err
);

  localparam logic [WD_W-1:0] GAP_LAST = WD_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0] WD_LIM   = WD_W'(WD_CYCLES);
  localparam state_t          AFTER_LO = (GAP_CYCLES == 0) ? START : GAP;

  state_t            state_q, state_n;
  logic [47:0]       shift_q, shift_n;
  logic [47:0]       buf_q, buf_n;
  logic              buf_full_q, buf_full_n;
  logic [2:0]        byte_cnt_q, byte_cnt_n;
  logic [WD_W-1:0]   cnt_q, cnt_n;
  logic [7:0]        tx_data_q;
  logic              frame_end, wd_abort, ovf;

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    buf_n      = buf_q;
    buf_full_n = buf_full_q;
    byte_cnt_n = byte_cnt_q;
    cnt_n      = cnt_q;
    frame_end  = 1'b0;
    wd_abort   = 1'b0;
    ovf        = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_en) begin
          shift_n    = data_i;
          byte_cnt_n = 3'd0;
          state_n    = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT_HI;
      end
      WAIT_HI: begin
        // Shared counter acts as the watchdog while waiting for tx_busy to rise
        if (tx_busy) begin
          state_n = WAIT_LO;
        end else if (cnt_q == WD_LIM) begin
          wd_abort = 1'b1;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt_q + WD_W'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_cnt_q == LAST_BYTE) begin
            frame_end = 1'b1;
            if (buf_full_q) begin
              shift_n    = buf_q;
              byte_cnt_n = 3'd0;
              buf_full_n = 1'b0;
              state_n    = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            shift_n    = {shift_q[39:0], 8'h00};
            byte_cnt_n = byte_cnt_q + 3'd1;
            cnt_n      = '0;
            state_n    = AFTER_LO;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_n = START;
        else                   cnt_n   = cnt_q + WD_W'(1);
      end
      default: state_n = IDLE;
    endcase

    // Buffer slot freed by a same-cycle reload is immediately reusable
    if (data_en && state_q != IDLE) begin
      if (!buf_full_n) begin
        buf_n      = data_i;
        buf_full_n = 1'b1;
      end else begin
        ovf = 1'b1;
      end
    end

    if (wd_abort) buf_full_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      byte_cnt_q <= 3'd0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      buf_q      <= buf_n;
      buf_full_q <= buf_full_n;
      byte_cnt_q <= byte_cnt_n;
      cnt_q      <= cnt_n;
      // START is always left after one cycle, so this fires only on entry
      if (state_n == START) tx_data_q <= shift_n[47:40];
    end
  end

  assign tx_start   = (state_q == START);
  assign tx_data    = tx_data_q;
  assign busy_o     = (state_q != IDLE);
  assign ready_o    = (state_q == IDLE) || !buf_full_q;
  assign o_byte_cnt = byte_cnt_q;
  assign done       = frame_end;
  assign err        = wd_abort | ovf;

endmodule

// File: tb/tb_data_split.sv
// Scoreboard bench for data_split: a GAP_CYCLES=16 instance carries the main
// scenarios, a GAP_CYCLES=0 instance checks the zero-gap byte spacing.
module tb_data_split;

  logic        clk, rst_n;
  logic [47:0] data_i, data_i0;
  logic        data_en, data_en0;
  logic        ready_o, ready0;
  logic [7:0]  tx_data, tx_data0;
  logic        tx_start, tx_start0;
  logic        tx_busy, tx_busy0;
  logic        busy_o, busy0;
  logic [2:0]  o_byte_cnt, byte_cnt0;
  logic        done, done0;
  logic        err, err0;
  logic        uart_en;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, last_start_cyc = 0;
  int start0_cnt = 0, done0_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];

  data_split #(.GAP_CYCLES(16), .WD_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_en(data_en),
    .ready_o(ready_o), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy_o(busy_o), .o_byte_cnt(o_byte_cnt),
    .done(done), .err(err));

  data_split #(.GAP_CYCLES(0), .WD_CYCLES(100)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i0), .data_en(data_en0),
    .ready_o(ready0), .tx_data(tx_data0), .tx_start(tx_start0),
    .tx_busy(tx_busy0), .busy_o(busy0), .o_byte_cnt(byte_cnt0),
    .done(done0), .err(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART models: busy for 10 clocks after each accepted start
  logic [3:0] bcnt, bcnt0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   bcnt <= 4'd0;
    else if (tx_start && uart_en) bcnt <= 4'd10;
    else if (bcnt != 4'd0)        bcnt <= bcnt - 4'd1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              bcnt0 <= 4'd0;
    else if (tx_start0)      bcnt0 <= 4'd10;
    else if (bcnt0 != 4'd0)  bcnt0 <= bcnt0 - 4'd1;
  end
  assign tx_busy  = (bcnt != 4'd0);
  assign tx_busy0 = (bcnt0 != 4'd0);

  function automatic void check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void push_frame(input logic [47:0] w);
    for (int i = 0; i < 6; i++) exp_q.push_back(w[47-8*i -: 8]);
  endfunction

  // kind 0: done, 1: err, 2: o_byte_cnt == tgt
  task automatic wait_ev(input int kind, input int tgt, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((kind == 0 && done) || (kind == 1 && err) ||
          (kind == 2 && o_byte_cnt == 3'(tgt))) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL %s: event not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_en(input logic [47:0] w);
    data_i  = w;
    data_en = 1'b1;
    @(posedge clk); #1;
    data_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"},  48'(tx_data), 48'h0);
    check({tag, "_tx_start"}, 48'(tx_start), 48'h0);
    check({tag, "_done"},     48'(done), 48'h0);
    check({tag, "_err"},      48'(err), 48'h0);
    check({tag, "_busy"},     48'(busy_o), 48'h0);
    check({tag, "_byte_cnt"}, 48'(o_byte_cnt), 48'h0);
    check({tag, "_ready"},    48'(ready_o), 48'h1);
  endtask

  // Monitor for the GAP_CYCLES=16 instance
  initial begin
    int fall_cyc;
    bit fall_valid, prev_busy;
    fall_cyc = 0; fall_valid = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          start_cnt++;
          last_start_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL tx_data: unexpected tx_start carrying %0h", tx_data);
          end else begin
            check("tx_data", 48'(tx_data), 48'(exp_q.pop_front()));
          end
          if (o_byte_cnt != 3'd0 && fall_valid)
            check("gap16_interval", 48'(cyc - fall_cyc), 48'd17);
          fall_valid = 1'b0;
        end
        if (prev_busy && !tx_busy) begin
          fall_cyc   = cyc;
          fall_valid = 1'b1;
        end
        prev_busy = tx_busy;
        if (done) done_cnt++;
        if (err)  err_cnt++;
      end
    end
  end

  // Monitor for the GAP_CYCLES=0 instance
  initial begin
    int fall_cyc;
    bit fall_valid, prev_busy;
    fall_cyc = 0; fall_valid = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start0) begin
          start0_cnt++;
          if (exp0_q.size() == 0) begin
            n_checks++;
            $display("FAIL tx_data0: unexpected tx_start carrying %0h", tx_data0);
          end else begin
            check("tx_data0", 48'(tx_data0), 48'(exp0_q.pop_front()));
          end
          if (byte_cnt0 != 3'd0 && fall_valid)
            check("gap0_interval", 48'(cyc - fall_cyc), 48'd1);
          fall_valid = 1'b0;
        end
        if (prev_busy && !tx_busy0) begin
          fall_cyc   = cyc;
          fall_valid = 1'b1;
        end
        prev_busy = tx_busy0;
        if (done0) done0_cnt++;
      end
    end
  end

  // Zero-gap instance: one frame right after reset release
  initial begin
    logic [47:0] w0;
    data_en0 = 1'b0;
    data_i0  = '0;
    w0       = 48'h0123456789AB;
    @(posedge rst_n);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) exp0_q.push_back(w0[47-8*i -: 8]);
    data_i0  = w0;
    data_en0 = 1'b1;
    @(posedge clk); #1;
    data_en0 = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst_n   = 1'b0;
    data_en = 1'b0;
    data_i  = '0;
    uart_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("por");

    // Single frame and first-byte latency
    @(posedge clk); #1;
    push_frame(48'h0123456789AB);
    pulse_en(48'h0123456789AB);
    @(negedge clk);
    check("latency_tx_start", 48'(tx_start), 48'h1);
    check("latency_tx_data",  48'(tx_data), 48'h01);
    wait_ev(0, 0, 400, "frame1_done");
    @(negedge clk);
    check("frame1_done_cnt", 48'(done_cnt), 48'd1);
    check("frame1_starts",   48'(start_cnt), 48'd6);
    check("frame1_idle",     48'(busy_o), 48'h0);

    // Back-to-back frame plus an overflowing third word
    @(posedge clk); #1;
    push_frame(48'h0123456789AB);
    pulse_en(48'h0123456789AB);
    wait_ev(2, 2, 200, "reach_byte2");
    @(posedge clk); #1;
    check("ready_buf_empty", 48'(ready_o), 48'h1);
    push_frame(48'hA5A5A5A5A5A5);
    pulse_en(48'hA5A5A5A5A5A5);
    @(negedge clk);
    check("ready_buf_full", 48'(ready_o), 48'h0);
    @(posedge clk); #1;
    data_i  = 48'hFFEEDDCCBBAA;
    data_en = 1'b1;
    @(negedge clk);
    check("overflow_err", 48'(err), 48'h1);
    @(posedge clk); #1;
    data_en = 1'b0;
    wait_ev(0, 0, 400, "b2b_done1");
    @(negedge clk);
    check("reload_tx_start", 48'(tx_start), 48'h1);
    check("reload_tx_data",  48'(tx_data), 48'hA5);
    wait_ev(0, 0, 400, "b2b_done2");
    @(negedge clk);
    check("b2b_starts",   48'(start_cnt), 48'd18);
    check("b2b_done_cnt", 48'(done_cnt), 48'd3);
    check("b2b_err_cnt",  48'(err_cnt), 48'd1);
    check("b2b_idle",     48'(busy_o), 48'h0);

    // Watchdog: transmitter never raises busy
    uart_en = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(8'hDE);
    pulse_en(48'hDEADBEEF0000);
    wait_ev(1, 0, 300, "wd_err");
    check("wd_latency", 48'(cyc - last_start_cyc), 48'd101);
    @(negedge clk);
    check("wd_idle",     48'(busy_o), 48'h0);
    check("wd_no_done",  48'(done_cnt), 48'd3);
    check("wd_err_cnt",  48'(err_cnt), 48'd2);
    uart_en = 1'b1;

    // Reset in the middle of byte3
    @(posedge clk); #1;
    push_frame(48'h102030405060);
    pulse_en(48'h102030405060);
    wait_ev(2, 3, 300, "reach_byte3");
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_done", 48'(done_cnt), 48'd3);
    check("midrst_no_err",  48'(err_cnt), 48'd2);
    @(posedge clk); #1;
    push_frame(48'hCAFEF00D1234);
    pulse_en(48'hCAFEF00D1234);
    wait_ev(0, 0, 400, "post_rst_done");
    @(negedge clk);
    check("post_rst_done_cnt", 48'(done_cnt), 48'd4);

    check("sb_drained",  48'(exp_q.size()), 48'd0);
    check("gap0_starts", 48'(start0_cnt), 48'd6);
    check("gap0_done",   48'(done0_cnt), 48'd1);
    check("sb0_drained", 48'(exp0_q.size()), 48'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_split.md
DATA_SPLIT -- requirements
Module: data_split

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, meaning the idle clocks inserted between consecutive bytes after tx_busy falls (range 0..255).
REQ-002 SHALL have parameter WD_CYCLES, default 10_000_000, meaning the watchdog limit in clocks for tx_busy to rise after tx_start (range 1..2^27-1).
REQ-003 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_i  input  48  word to transmit; byte0 = data_i[47:40], byte5 = data_i[7:0].
REQ-006 SHALL have port data_en  input  1  one-cycle strobe; data_i is valid in the same cycle.
REQ-007 SHALL have port ready_o  output  1  high when a data_en would be accepted without loss.
REQ-008 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start  output  1  one-cycle request to the UART transmitter.
REQ-010 SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-011 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port o_byte_cnt  output  3  index (0..5) of the byte currently in flight.
REQ-013 SHALL have port done  output  1  one-cycle pulse when byte5 completes.
REQ-014 SHALL have port err  output  1  one-cycle pulse on watchdog abort or overflow.

Function
REQ-015 SHALL implement the FSM states IDLE, START, WAIT_HI, WAIT_LO and GAP.
REQ-016 In IDLE, data_en SHALL load the shift word, clear the byte count and move to START on the next edge.
REQ-017 START SHALL drive tx_start=1 for exactly one cycle with tx_data equal to the current byte, then go to WAIT_HI.
REQ-018 Latency: data_en in IDLE at cycle N SHALL give tx_start at cycle N+1 with tx_data = data_i[47:40].
REQ-019 tx_data SHALL hold its value from START until the next START.
REQ-020 WAIT_HI SHALL go to WAIT_LO when tx_busy=1.
REQ-021 If tx_busy stays 0 for WD_CYCLES clocks in WAIT_HI, the block SHALL pulse err, discard the frame and the holding buffer, and go to IDLE.
REQ-022 WAIT_LO SHALL wait for tx_busy=0. If the byte count is 5, the block SHALL pulse done in that same cycle and go to IDLE; otherwise it SHALL increment the byte count and go to GAP.
REQ-023 WAIT_LO SHALL have no timeout.
REQ-024 GAP SHALL count GAP_CYCLES clocks and then go to START; with GAP_CYCLES=0 it SHALL go directly from WAIT_LO to START.
REQ-025 The block SHALL contain a one-word holding buffer.
REQ-026 data_en while busy_o=1 and the buffer is empty SHALL capture data_i into the buffer and set the buffer full.
REQ-027 ready_o SHALL equal (IDLE or buffer empty).
REQ-028 data_en while the buffer is full and not IDLE SHALL be dropped, pulse err and leave the buffer unchanged.
REQ-029 When byte5 completes with the buffer full, the block SHALL load the buffer and go to START instead of IDLE, and the buffer SHALL become empty in the same cycle.
REQ-030 A data_en in the same cycle as the REQ-029 reload SHALL be captured into the now-empty buffer.
REQ-031 The byte count SHALL never exceed 5; its wrap from 5 to 0 occurs only on a frame load.

Reset
REQ-032 On rst_n=0, the block SHALL asynchronously set the FSM to IDLE and clear the buffer, the counters and the shift word.
REQ-033 Reset values of outputs: tx_data=0, tx_start=0, done=0, err=0, busy_o=0, o_byte_cnt=0, ready_o=1 from the first edge after release.
REQ-034 Reset mid-frame SHALL abandon the frame silently, with no done or err pulse.
REQ-035 The watchdog counter SHALL be cleared by reset and on every entry to WAIT_HI.

Structure
REQ-036 The shared package SHALL hold the FSM state encoding, FRAME_BYTES=6 and the watchdog counter width of 27.
REQ-037 The block SHALL be a single module with no sub-modules; the GAP and watchdog counters MAY share one counter register.

Verification
REQ-038 Single frame: data_en with 0x0123456789AB and a UART model that is busy 10 clocks after each start -> six tx_start pulses with tx_data 01,23,45,67,89,AB in order, then one done pulse.
REQ-039 Back-to-back: second data_en with 0xA5A5A5A5A5A5 during byte2 -> ready_o goes 0; after done, the next tx_start follows within 1 clock with tx_data=A5; twelve bytes total.
REQ-040 Overflow: third data_en while the buffer is full -> err pulse; only two frames are transmitted.
REQ-041 Watchdog: tx_busy held 0, WD_CYCLES=100 -> err 100 clocks after WAIT_HI entry; FSM in IDLE; no done pulse.
REQ-042 Reset asserted during byte3 -> all outputs at reset values; a following frame transmits correctly starting from byte0.
REQ-043 GAP_CYCLES=0 and 16 -> the interval from tx_busy falling to the next tx_start is 1 clock and 17 clocks respectively.
